// File: rtl/result_bcd_decoder_pkg.sv
// Shared definitions for the result-side binary-to-BCD converter.
package result_bcd_decoder_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned DIGITS_DEF = 10;

    // Converter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Counter must hold WIDTH+1 (shift count loaded at START)
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

    // True when DIGITS decimal digits cover every (WIDTH+1)-bit magnitude: 10**D > 2**(W+1)
    function automatic bit digits_ok(input int unsigned width, input int unsigned digits);
        longint unsigned lim;
        longint unsigned p10;
        lim = 64'd1 << (width + 1);
        p10 = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            if (p10 <= lim) p10 = p10 * 64'd10;
        end
        return p10 > lim;
    endfunction

endpackage

// File: rtl/result_bcd_decoder_bcd_digit_adj.sv
// Double-dabble correction cell: add 3 to any BCD digit of 5 or more before a shift.
module result_bcd_decoder_bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout_c
);

    assign dout_c = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/result_bcd_decoder.sv
// Sign/magnitude recovery of an adder result followed by iterative double-dabble to BCD.
module result_bcd_decoder
    import result_bcd_decoder_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  CLK,
    input  logic                  SCLR,
    input  logic                  CE,
    input  logic                  START,
    input  logic                  ADD,
    input  logic                  C_IN,
    input  logic [WIDTH-1:0]      S_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  NEG,
    output logic [4*DIGITS-1:0]   BCD
);

    localparam int unsigned MAG_W = WIDTH + 1;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
        $error("result_bcd_decoder: DIGITS too small for WIDTH+1 bit magnitude");
    end

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [MAG_W-1:0]   mag_q,    mag_d;
    logic [BCD_W-1:0]   scr_q,    scr_d;
    logic [BCD_W-1:0]   bcd_q,    bcd_d;
    logic               neg_q,    neg_d;
    logic               neg_nx_q, neg_nx_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [MAG_W-1:0]   r_c;
    logic               is_neg_c;
    logic [BCD_W-1:0]   adj_c;
    logic [BCD_W-1:0]   scr_shift_c;

    // Digit corrections applied to the scratch before each shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        result_bcd_decoder_bcd_digit_adj u_adj (
            .din    (scr_q[4*g +: 4]),
            .dout_c (adj_c[4*g +: 4])
        );
    end

    // Source result and its sign; a borrow on a difference means negative
    assign r_c         = {C_IN, S_IN};
    assign is_neg_c    = !ADD && C_IN;
    assign scr_shift_c = {adj_c[BCD_W-2:0], mag_q[MAG_W-1]};

    // Next-state and datapath: load on accepted START, shift while counting down
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        scr_d    = scr_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        neg_nx_d = neg_nx_q;
        busy_d   = busy_q;
        done_d   = done_q;
        if (CE) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_d  = ST_SHIFT;
                        mag_d    = is_neg_c ? MAG_W'(~r_c + MAG_W'(1)) : r_c;
                        neg_nx_d = is_neg_c;
                        scr_d    = '0;
                        cnt_d    = CNT_W'(MAG_W);
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    scr_d = scr_shift_c;
                    mag_d = {mag_q[MAG_W-2:0], 1'b0};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        bcd_d   = scr_shift_c;
                        neg_d   = neg_nx_q;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge CLK or posedge SCLR) begin
        if (SCLR) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mag_q    <= '0;
            scr_q    <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            neg_nx_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            scr_q    <= scr_d;
            bcd_q    <= bcd_d;
            neg_q    <= neg_d;
            neg_nx_q <= neg_nx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign NEG  = neg_q;
    assign BCD  = bcd_q;

endmodule

// File: tb/tb_result_bcd_decoder.sv
// Directed bench for result_bcd_decoder: vector table plus handshake corner sequences.
module tb_result_bcd_decoder;

    logic        CLK = 1'b0;
    logic        SCLR;
    logic        CE;
    logic        START;
    logic        ADD;
    logic        C_IN;
    logic [31:0] S_IN;
    logic        BUSY;
    logic        DONE;
    logic        NEG;
    logic [39:0] BCD;

    int checks = 0;
    int errors = 0;

    logic [39:0] prev_bcd;
    logic        prev_neg;

    typedef struct {
        string       name;
        logic        add;
        logic        cin;
        logic [31:0] s;
        logic [39:0] bcd;
        logic        neg;
    } vec_t;

    vec_t vecs[9];

    result_bcd_decoder #(.WIDTH(32), .DIGITS(10)) dut (
        .CLK   (CLK),
        .SCLR  (SCLR),
        .CE    (CE),
        .START (START),
        .ADD   (ADD),
        .C_IN  (C_IN),
        .S_IN  (S_IN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .NEG   (NEG),
        .BCD   (BCD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One conversion; optional ignored START at inj_edge, optional 5-cycle CE gap from ce_edge
    task automatic run_conv(input string name, input logic add, input logic cin,
                            input logic [31:0] s, input logic [39:0] exp_bcd,
                            input logic exp_neg, input int inj_edge, input int ce_edge);
        int   edges;
        int   exp_lat;
        logic held_ok;
        held_ok = 1'b1;
        exp_lat = (ce_edge > 0) ? 39 : 34;
        @(negedge CLK);
        CE = 1'b1; ADD = add; C_IN = cin; S_IN = s; START = 1'b1;
        @(posedge CLK);
        #1;
        edges = 1;
        START = 1'b0;
        ADD = 1'($urandom); C_IN = 1'($urandom); S_IN = $urandom;
        while (!DONE && edges < 100) begin
            if (BUSY !== 1'b1 || BCD !== prev_bcd || NEG !== prev_neg) held_ok = 1'b0;
            if (inj_edge > 0 && edges == inj_edge) begin
                START = 1'b1; ADD = 1'b1; C_IN = 1'b0; S_IN = 32'd9;
            end
            if (inj_edge > 0 && edges == inj_edge + 1) START = 1'b0;
            if (ce_edge > 0 && edges == ce_edge) CE = 1'b0;
            if (ce_edge > 0 && edges == ce_edge + 5) CE = 1'b1;
            @(posedge CLK);
            #1;
            edges++;
        end
        chk({name, " latency"}, 64'(edges), 64'(exp_lat));
        chk({name, " held/busy during shift"}, 64'(held_ok), 64'd1);
        chk({name, " BCD"}, 64'(BCD), 64'(exp_bcd));
        chk({name, " NEG"}, 64'(NEG), 64'(exp_neg));
        chk({name, " BUSY at done"}, 64'(BUSY), 64'd0);
        @(posedge CLK);
        #1;
        chk({name, " DONE persists"}, 64'(DONE), 64'd1);
        prev_bcd = exp_bcd;
        prev_neg = exp_neg;
    endtask

    initial begin
        vecs[0] = '{"sum 12345",      1'b1, 1'b0, 32'd12345,     40'h0000012345, 1'b0};
        vecs[1] = '{"diff -1",        1'b0, 1'b1, 32'hFFFFFFFF,  40'h0000000001, 1'b1};
        vecs[2] = '{"max sum",        1'b1, 1'b1, 32'hFFFFFFFE,  40'h8589934590, 1'b0};
        vecs[3] = '{"boundary -2^32", 1'b0, 1'b1, 32'h00000000,  40'h4294967296, 1'b1};
        vecs[4] = '{"zero",           1'b1, 1'b0, 32'h00000000,  40'h0000000000, 1'b0};
        vecs[5] = '{"sum 2^32-1",     1'b1, 1'b0, 32'hFFFFFFFF,  40'h4294967295, 1'b0};
        vecs[6] = '{"diff +100",      1'b0, 1'b0, 32'd100,       40'h0000000100, 1'b0};
        vecs[7] = '{"diff -100",      1'b0, 1'b1, 32'hFFFFFF9C,  40'h0000000100, 1'b1};
        vecs[8] = '{"sum carry 2^32", 1'b1, 1'b1, 32'h00000000,  40'h4294967296, 1'b0};

        SCLR = 1'b1; CE = 1'b0; START = 1'b0; ADD = 1'b0; C_IN = 1'b0; S_IN = '0;
        prev_bcd = '0;
        prev_neg = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset BUSY", 64'(BUSY), 64'd0);
        chk("reset DONE", 64'(DONE), 64'd0);
        chk("reset NEG",  64'(NEG),  64'd0);
        chk("reset BCD",  64'(BCD),  64'd0);
        @(negedge CLK);
        SCLR = 1'b0;
        CE = 1'b1;

        foreach (vecs[i]) begin
            run_conv(vecs[i].name, vecs[i].add, vecs[i].cin, vecs[i].s,
                     vecs[i].bcd, vecs[i].neg, 0, 0);
        end

        // START during SHIFT is dropped
        run_conv("ignored start", 1'b1, 1'b0, 32'd7, 40'h7, 1'b0, 10, 0);

        // CE gap stretches latency by 5 clocks
        run_conv("ce gap", 1'b1, 1'b0, 32'd99, 40'h99, 1'b0, 0, 12);

        // Reset mid-conversion clears outputs at once
        @(negedge CLK);
        CE = 1'b1; ADD = 1'b0; C_IN = 1'b1; S_IN = 32'hFFFFEA46; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        chk("pre-reset BUSY", 64'(BUSY), 64'd1);
        SCLR = 1'b1;
        #1;
        chk("abort BUSY", 64'(BUSY), 64'd0);
        chk("abort DONE", 64'(DONE), 64'd0);
        chk("abort NEG",  64'(NEG),  64'd0);
        chk("abort BCD",  64'(BCD),  64'd0);
        @(negedge CLK);
        SCLR = 1'b0;
        prev_bcd = '0;
        prev_neg = 1'b0;
        run_conv("post-reset zero", 1'b1, 1'b0, 32'd0, 40'h0, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
